mux_pipe_n1: RTL and testbench

Parametrised, pipelined N:1 multiplexer tree with valid tracking, stall and flush; the pipelined successor of the 16:1 bit mux. It selects one of N WIDTH-bit lanes using a binary select. Pipeline registers sit between groups of 2:1 levels, so wide selects (register-file read ports, forwarding muxes) close timing in the pipelined CPU. Select bits and valid travel with the data, so the result always corresponds to the select presented in the same cycle as the data.

---
 rtl/mux_pipe_n1.sv | 110 +++++++++++
 tb/tb_mux_pipe_n1.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_pipe_n1.sv
// Pipelined N:1 multiplexer tree with valid tracking, stall and flush.
// Each stage resolves STAGE_LEVELS select bits (LSB first) and registers the surviving lanes.
module mux_pipe_n1 #(
    parameter int WIDTH        = 64,
    parameter int N            = 16,
    parameter int STAGE_LEVELS = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [N*WIDTH-1:0]   in,
    input  logic [$clog2(N)-1:0] sel,
    input  logic                 in_valid,
    input  logic                 en,
    input  logic                 flush,
    output logic [WIDTH-1:0]     out,
    output logic                 out_valid
);

    localparam int L   = $clog2(N);
    localparam int LAT = (L + STAGE_LEVELS - 1) / STAGE_LEVELS;

    for (genvar s = 0; s < LAT; s++) begin : g_stage
        localparam int LO   = s * STAGE_LEVELS;
        localparam int NL   = (L - LO < STAGE_LEVELS) ? (L - LO) : STAGE_LEVELS;
        localparam int NIN  = N >> LO;
        localparam int NOUT = NIN >> NL;
        localparam int SIN  = L - LO;
        localparam int SOUT = SIN - NL;

        logic [NIN*WIDTH-1:0]  din;
        logic [SIN-1:0]        sin;
        logic                  vin;
        logic [NOUT*WIDTH-1:0] mux_y;
        logic [NOUT*WIDTH-1:0] data_q;
        logic                  valid_q;
        logic                  load;

        if (s == 0) begin : g_src
            assign din = in;
            assign sin = sel;
            assign vin = in_valid;
        end else begin : g_src
            assign din = g_stage[s-1].data_q;
            assign sin = g_stage[s-1].g_sel.q;
            assign vin = g_stage[s-1].valid_q;
        end

        // Level l of this stage halves the lane count using select bit l of the remaining bits.
        for (genvar l = 0; l < NL; l++) begin : g_lvl
            localparam int M = NIN >> (l + 1);
            logic [2*M*WIDTH-1:0] x;
            logic [M*WIDTH-1:0]   y;

            if (l == 0) begin : g_x
                assign x = din;
            end else begin : g_x
                assign x = g_lvl[l-1].y;
            end

            for (genvar j = 0; j < M; j++) begin : g_pair
                assign y[j*WIDTH +: WIDTH] = sin[l] ? x[(2*j+1)*WIDTH +: WIDTH]
                                                    : x[(2*j)*WIDTH +: WIDTH];
            end
        end

        assign mux_y = g_lvl[NL-1].y;

        // Bubbles and flushed slots never overwrite data, so out keeps the last real result.
        assign load = en & vin & ~flush;

        // NOTE: registers use non-blocking assignments so every stage samples its upstream
        // value from before the edge; blocking here would let a request skip stages.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                valid_q <= 1'b0;
            end else if (flush) begin
                valid_q <= 1'b0;
            end else if (en) begin
                valid_q <= vin;
            end
        end

        // NOTE: the data bank is an ordinary register, not a memory, so it is reset with
        // the valid bits to give a deterministic out=0 after reset.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                data_q <= '0;
            end else if (load) begin
                data_q <= mux_y;
            end
        end

        // Unresolved select bits travel alongside their partial results.
        if (SOUT > 0) begin : g_sel
            logic [SOUT-1:0] q;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    q <= '0;
                end else if (load) begin
                    q <= sin[SIN-1:NL];
                end
            end
        end
    end

    assign out       = g_stage[LAT-1].data_q;
    assign out_valid = g_stage[LAT-1].valid_q;

endmodule

// File: tb/tb_mux_pipe_n1.sv
// Self-checking bench for mux_pipe_n1: scoreboard on the main 16x8 instance,
// plus direct checks on three parameter-corner instances.
module tb_mux_pipe_n1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n, en, flush;

    // main instance: WIDTH=8, N=16, STAGE_LEVELS=2
    logic [127:0]  in_m;
    logic [3:0]    sel_m;
    logic          v_m;
    logic [7:0]    out_m;
    logic          ov_m;

    // corner a: N=2, STAGE_LEVELS=1
    logic [15:0]   in_a;
    logic [0:0]    sel_a;
    logic          v_a;
    logic [7:0]    out_a;
    logic          ov_a;

    // corner b: N=8, STAGE_LEVELS=2
    logic [63:0]   in_b;
    logic [2:0]    sel_b;
    logic          v_b;
    logic [7:0]    out_b;
    logic          ov_b;

    // corner c: WIDTH=64, N=16
    logic [1023:0] in_c;
    logic [3:0]    sel_c;
    logic          v_c;
    logic [63:0]   out_c;
    logic          ov_c;

    mux_pipe_n1 #(.WIDTH(8), .N(16), .STAGE_LEVELS(2)) dut_m (
        .clk(clk), .reset_n(reset_n), .in(in_m), .sel(sel_m), .in_valid(v_m),
        .en(en), .flush(flush), .out(out_m), .out_valid(ov_m)
    );

    mux_pipe_n1 #(.WIDTH(8), .N(2), .STAGE_LEVELS(1)) dut_a (
        .clk(clk), .reset_n(reset_n), .in(in_a), .sel(sel_a), .in_valid(v_a),
        .en(en), .flush(flush), .out(out_a), .out_valid(ov_a)
    );

    mux_pipe_n1 #(.WIDTH(8), .N(8), .STAGE_LEVELS(2)) dut_b (
        .clk(clk), .reset_n(reset_n), .in(in_b), .sel(sel_b), .in_valid(v_b),
        .en(en), .flush(flush), .out(out_b), .out_valid(ov_b)
    );

    mux_pipe_n1 #(.WIDTH(64), .N(16), .STAGE_LEVELS(2)) dut_c (
        .clk(clk), .reset_n(reset_n), .in(in_c), .sel(sel_c), .in_valid(v_c),
        .en(en), .flush(flush), .out(out_c), .out_valid(ov_c)
    );

    int         n_chk = 0;
    int         n_pass = 0;
    int         pops = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    task automatic set_lanes();
        for (int k = 0; k < 16; k++) in_m[k*8 +: 8] = 8'(k * 17);
    endtask

    // One clock: sample inputs at the edge, then score the main instance 1ns later.
    task automatic tick();
        logic         e_edge, f_edge, v_edge;
        logic [3:0]   s_edge;
        logic [127:0] in_edge;
        logic [7:0]   exp;
        @(posedge clk);
        e_edge  = en;
        f_edge  = flush;
        v_edge  = v_m;
        s_edge  = sel_m;
        in_edge = in_m;
        #1;
        if (f_edge) begin
            exp_q.delete();
        end else begin
            if (ov_m && e_edge) begin
                if (exp_q.size() == 0) begin
                    check("sb_spurious_vld", 64'(ov_m), 64'(1'b0));
                end else begin
                    exp = exp_q.pop_front();
                    pops++;
                    check("sb_data", 64'(out_m), 64'(exp));
                end
            end
            if (e_edge && v_edge) exp_q.push_back(in_edge[s_edge*8 +: 8]);
        end
    endtask

    initial begin
        logic [7:0]  so;
        logic        sv;
        logic [63:0] exp_c;

        reset_n = 1'b0;
        en = 1'b1;
        flush = 1'b0;
        set_lanes();
        sel_m = '0; v_m = 1'b0;
        in_a = '0; sel_a = '0; v_a = 1'b0;
        in_b = '0; sel_b = '0; v_b = 1'b0;
        in_c = '0; sel_c = '0; v_c = 1'b0;

        #1;
        check("rst_out", 64'(out_m), 64'h0);
        check("rst_vld", 64'(ov_m), 64'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        tick();

        // single request sel=5
        sel_m = 4'd5; v_m = 1'b1;
        tick();
        v_m = 1'b0;
        check("single_vld_early", 64'(ov_m), 64'h0);
        tick();
        check("single_out", 64'(out_m), 64'h55);
        check("single_vld", 64'(ov_m), 64'h1);
        in_m = {$urandom, $urandom, $urandom, $urandom};
        tick();
        check("single_vld_drop", 64'(ov_m), 64'h0);
        check("single_hold", 64'(out_m), 64'h55);
        set_lanes();
        tick();

        // streaming 0..15 with a 3-cycle stall after sel=6 is accepted
        pops = 0;
        for (int i = 0; i < 16; i++) begin
            sel_m = 4'(i); v_m = 1'b1; en = 1'b1;
            tick();
            if (i == 6) begin
                en = 1'b0;
                sel_m = 4'd7;
                so = out_m;
                sv = ov_m;
                check("stall_out_val", 64'(out_m), 64'h55);
                for (int k = 0; k < 3; k++) begin
                    tick();
                    check("stall_out", 64'(out_m), 64'(so));
                    check("stall_vld", 64'(ov_m), 64'(sv));
                end
                en = 1'b1;
            end
        end
        v_m = 1'b0;
        tick();
        check("stream_count", 64'(pops), 64'd16);
        tick();

        // flush with en=0 and a new request while two are in flight
        sel_m = 4'd1; v_m = 1'b1;
        tick();
        sel_m = 4'd2;
        tick();
        flush = 1'b1; en = 1'b0; sel_m = 4'd9; v_m = 1'b1;
        tick();
        check("flush_vld0", 64'(ov_m), 64'h0);
        check("flush_hold0", 64'(out_m), 64'h11);
        flush = 1'b0; en = 1'b1; v_m = 1'b0;
        for (int k = 1; k < 3; k++) begin
            tick();
            check("flush_vld", 64'(ov_m), 64'h0);
            check("flush_hold", 64'(out_m), 64'h11);
        end
        sel_m = 4'd3; v_m = 1'b1;
        tick();
        v_m = 1'b0;
        tick();
        check("post_flush_out", 64'(out_m), 64'h33);
        check("post_flush_vld", 64'(ov_m), 64'h1);

        // asynchronous reset mid-operation
        sel_m = 4'd10; v_m = 1'b1;
        tick();
        v_m = 1'b0;
        tick();
        check("pre_rst_out", 64'(out_m), 64'hAA);
        #3;
        reset_n = 1'b0;
        in_m = {$urandom, $urandom, $urandom, $urandom};
        sel_m = 4'($urandom);
        v_m = 1'b1;
        #1;
        check("rst_async_out", 64'(out_m), 64'h0);
        check("rst_async_vld", 64'(ov_m), 64'h0);
        exp_q.delete();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        v_m = 1'b0;
        set_lanes();
        for (int k = 0; k < 2; k++) begin
            tick();
            check("rst_rel_out", 64'(out_m), 64'h0);
            check("rst_rel_vld", 64'(ov_m), 64'h0);
        end

        // parameter corners, each asking for the top lane
        in_a = {8'hC3, 8'h3C};
        for (int k = 0; k < 8; k++) in_b[k*8 +: 8] = 8'(k * 17);
        for (int w = 0; w < 32; w++) in_c[w*32 +: 32] = $urandom;
        exp_c = in_c[15*64 +: 64];
        sel_a = 1'b1; v_a = 1'b1;
        sel_b = 3'd7; v_b = 1'b1;
        sel_c = 4'd15; v_c = 1'b1;
        tick();
        v_a = 1'b0; v_b = 1'b0; v_c = 1'b0;
        check("n2_out", 64'(out_a), 64'hC3);
        check("n2_vld", 64'(ov_a), 64'h1);
        check("n8_vld_early", 64'(ov_b), 64'h0);
        check("w64_vld_early", 64'(ov_c), 64'h0);
        in_c = '0;
        tick();
        check("n8_out", 64'(out_b), 64'h77);
        check("n8_vld", 64'(ov_b), 64'h1);
        check("w64_out", out_c, exp_c);
        check("w64_vld", 64'(ov_c), 64'h1);
        check("n2_vld_drop", 64'(ov_a), 64'h0);

        tick();
        check("sb_empty", 64'(exp_q.size()), 64'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
